// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader: shifts 2N words into row-major vectors A and B and
// holds them until the consumer accepts. Optional framing check under MATRIX_LOADER_ERR_EN.
module matrix_operand_loader #(
  parameter int unsigned word_size    = 32,
  parameter int unsigned matrixrownum = 2,
  parameter int unsigned matrixcolnum = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [word_size-1:0]                             in_data,
  input  logic                                             in_op,
  input  logic                                             in_last,
  output logic [matrixrownum*matrixcolnum*word_size-1:0]   A,
  output logic [matrixrownum*matrixcolnum*word_size-1:0]   B,
  output logic                                             op,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic                                             err
);

  localparam int unsigned N  = matrixrownum * matrixcolnum;
  localparam int unsigned CW = $clog2(2 * N);
  localparam int unsigned VW = N * word_size;
  localparam logic [CW-1:0] LastA = CW'(N - 1);
  localparam logic [CW-1:0] LastB = CW'(2 * N - 1);

  typedef enum logic [1:0] {StLoadA, StLoadB, StFull} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   a_d, b_d;
  logic            op_d;
  logic            in_fire;

  always_comb begin
    in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
    out_valid = (state_q == StFull);
    in_fire   = in_valid && in_ready;
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = A;
    b_d       = B;
    op_d      = op;
    unique case (state_q)
      StLoadA: begin
        if (in_fire) begin
          // First word received ends up in the top slice after N shifts.
          a_d                = A << word_size;
          a_d[word_size-1:0] = in_data;
          if (cnt_q == '0) op_d = in_op;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastA) state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (in_fire) begin
          b_d                = B << word_size;
          b_d[word_size-1:0] = in_data;
          if (cnt_q == LastB) begin
            state_d = StFull;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFull: begin
        if (out_ready) state_d = StLoadA;
      end
      default: state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadA;
      cnt_q   <= '0;
      A       <= '0;
      B       <= '0;
      op      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      A       <= a_d;
      B       <= b_d;
      op      <= op_d;
    end
  end

`ifdef MATRIX_LOADER_ERR_EN
  logic err_q;

  // Sticky: in_last must coincide exactly with the final B word.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_fire && (in_last != (cnt_q == LastB))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err            = 1'b0;
`endif

endmodule
